// File: rtl/dpi_mem_bridge_if.sv
// dpi_mem_bridge_if: LSU request/response channels plus the memory-model access port
interface dpi_mem_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        pmem_ren;
  logic        pmem_wen;
  logic [31:0] pmem_addr;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_mask;
  logic [31:0] pmem_rdata;
  modport slave (
    input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata, resp_ready, pmem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
    output pmem_ren, pmem_wen, pmem_addr, pmem_wdata, pmem_mask
  );
  modport master (
    output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );
  modport mem (
    input  pmem_ren, pmem_wen, pmem_addr, pmem_wdata, pmem_mask,
    output pmem_rdata
  );
endinterface

// File: rtl/dpi_mem_bridge.sv
// dpi_mem_bridge: sized load/store port with fixed response latency over a word memory model
module dpi_mem_bridge #(
  parameter int LATENCY         = 1,
  parameter bit ERR_ON_MISALIGN = 1
) (
  input logic             clock,
  input logic             reset,
  dpi_mem_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_accept, w_mis, w_err;
  logic [1:0]  w_lane;
  logic [31:0] w_x, w_ld;
  always_comb begin
    w_mis    = (bus.req_size == 2'd1 && bus.req_addr[0]) || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0);
    w_err    = bus.req_size == 2'd3 || (w_mis && ERR_ON_MISALIGN);
    w_lane   = !w_mis ? bus.req_addr[1:0] : bus.req_size == 2'd1 ? {bus.req_addr[1], 1'b0} : 2'd0;
    w_accept = bus.req_valid && bus.req_ready;
    w_x      = bus.pmem_rdata >> {w_lane, 3'b000};
    w_ld     = bus.req_size == 2'd0 ? {{24{~bus.req_unsigned & w_x[7]}}, w_x[7:0]} :
               bus.req_size == 2'd1 ? {{16{~bus.req_unsigned & w_x[15]}}, w_x[15:0]} : w_x;
  end
  always_ff @(posedge clock)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state == IDLE ? (w_accept ? (LATENCY > 1 ? WAIT : RESP) : IDLE) :
             r_state == WAIT ? (r_cnt == 4'd0 ? RESP : WAIT) :
             (bus.resp_ready ? IDLE : RESP);
  end
  always_comb begin
    bus.req_ready  = r_state == IDLE && !reset;
    bus.resp_valid = r_state == RESP;
    bus.busy       = r_state != IDLE;
    bus.resp_rdata = r_rdata;
    bus.resp_err   = r_err;
    bus.pmem_ren   = w_accept && !bus.req_wen && !w_err;
    bus.pmem_wen   = w_accept && bus.req_wen && !w_err;
    bus.pmem_addr  = {bus.req_addr[31:2], 2'b00};
    bus.pmem_wdata = bus.req_wdata << {w_lane, 3'b000};
    bus.pmem_mask  = bus.req_size == 2'd0 ? 4'b0001 << w_lane :
                     bus.req_size == 2'd1 ? 4'b0011 << w_lane : 4'b1111;
  end
  // The memory read is sampled at the accept edge, so the load result is final from then on
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= CNT_INIT;
      r_rdata <= (bus.req_wen || w_err) ? 32'd0 : w_ld;
      r_err   <= w_err;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_dpi_mem_bridge.sv
// tb_dpi_mem_bridge: three bridge configurations over one shared word memory model
module tb_dpi_mem_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, init_mem;
  int          sel;
  logic        t_v, t_rr, t_wen, t_uns;
  logic [31:0] t_addr, t_wdata;
  logic [1:0]  t_size;
  logic        rv[3], rdy[3], rerr[3], bsy[3], ren_a[3], wen_a[3];
  logic [31:0] rdat[3], wa_a[3], wd_a[3];
  logic [3:0]  wm_a[3];
  logic [31:0] mem[16];
  int          nr = 0, nw = 0, tests = 0, fails = 0;
  logic [31:0] last_wa, last_wd;
  logic [3:0]  last_wm;
  dpi_mem_bridge_if bus[3]();
  for (genvar k = 0; k < 3; k++) begin : g
    assign bus[k].req_valid    = t_v && sel == k;
    assign bus[k].resp_ready   = t_rr && sel == k;
    assign bus[k].req_wen      = t_wen;
    assign bus[k].req_addr     = t_addr;
    assign bus[k].req_size     = t_size;
    assign bus[k].req_unsigned = t_uns;
    assign bus[k].req_wdata    = t_wdata;
    assign bus[k].pmem_rdata   = mem[bus[k].pmem_addr[5:2]];
    assign rv[k]   = bus[k].resp_valid;
    assign rdy[k]  = bus[k].req_ready;
    assign rerr[k] = bus[k].resp_err;
    assign bsy[k]  = bus[k].busy;
    assign rdat[k] = bus[k].resp_rdata;
    assign ren_a[k] = bus[k].pmem_ren;
    assign wen_a[k] = bus[k].pmem_wen;
    assign wa_a[k]  = bus[k].pmem_addr;
    assign wd_a[k]  = bus[k].pmem_wdata;
    assign wm_a[k]  = bus[k].pmem_mask;
    dpi_mem_bridge #(.LATENCY(k == 1 ? 4 : k == 2 ? 2 : 1), .ERR_ON_MISALIGN(k != 2)) u (
      .clock(clk), .reset(rst), .bus(bus[k].slave));
  end
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 32'hDEADBEEF : 32'h0;
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (ren_a[j]) nr <= nr + 1;
        if (wen_a[j]) begin
          nw <= nw + 1;
          last_wa <= wa_a[j];
          last_wd <= wd_a[j];
          last_wm <= wm_a[j];
          for (int b = 0; b < 4; b++)
            if (wm_a[j][b]) mem[wa_a[j][5:2]][8*b +: 8] <= wd_a[j][8*b +: 8];
        end
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic xact(input int s, input logic wen, input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    logic [31:0] d0;
    sel = s; t_wen = wen; t_addr = a; t_size = sz; t_uns = u; t_wdata = wd; t_v = 1'b1; t_rr = 1'b0;
    n = 0;
    while (!rdy[s] && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin tests++; fails++; $display("FAIL accept_timeout: got no req_ready expected ready"); end
    @(negedge clk);
    t_v = 1'b0;
    lat = 1;
    while (!rv[s] && lat < 20) begin @(negedge clk); lat++; end
    rd = rdat[s];
    er = rerr[s];
    d0 = rd;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rv[s]}, 32'd1);
      chk("hold_rdata", rdat[s], d0);
    end
    t_rr = 1'b1;
    @(negedge clk);
    t_rr = 1'b0;
  endtask
  typedef struct {
    int s; logic wen; logic [31:0] addr; logic [1:0] size; logic uns; logic [31:0] wdata; int hold;
    logic [31:0] rd; logic err; int lat; int nr; int nw; logic [31:0] wa; logic [31:0] wd; logic [3:0] wm;
  } vec_t;
  vec_t vq[$];
  initial begin
    logic [31:0] rd;
    logic er;
    int lat, nr0, nw0;
    vq.push_back('{0, 1'b0, 32'h80000003, 2'd0, 1'b0, 32'h0, 0, 32'hFFFFFFDE, 1'b0, 1, 1, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{0, 1'b0, 32'h80000002, 2'd1, 1'b1, 32'h0, 0, 32'h0000DEAD, 1'b0, 1, 1, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{0, 1'b0, 32'h80000000, 2'd1, 1'b0, 32'h0, 0, 32'hFFFFBEEF, 1'b0, 1, 1, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{0, 1'b0, 32'h80000000, 2'd2, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1, 1, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{0, 1'b0, 32'h80000000, 2'd0, 1'b1, 32'h0, 2, 32'h000000EF, 1'b0, 1, 1, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{0, 1'b0, 32'h80000002, 2'd2, 1'b0, 32'h0, 0, 32'h00000000, 1'b1, 1, 0, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{0, 1'b0, 32'h80000001, 2'd1, 1'b0, 32'h0, 0, 32'h00000000, 1'b1, 1, 0, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{0, 1'b0, 32'h80000000, 2'd3, 1'b0, 32'h0, 0, 32'h00000000, 1'b1, 1, 0, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{2, 1'b0, 32'h80000002, 2'd2, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{2, 1'b0, 32'h80000003, 2'd1, 1'b0, 32'h0, 0, 32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{0, 1'b1, 32'h80000001, 2'd0, 1'b0, 32'h000000AA, 0, 32'h0, 1'b0, 1, 0, 1, 32'h80000000, 32'h0000AA00, 4'b0010});
    vq.push_back('{0, 1'b0, 32'h80000000, 2'd2, 1'b0, 32'h0, 0, 32'hDEADAAEF, 1'b0, 1, 1, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{0, 1'b1, 32'h80000006, 2'd1, 1'b0, 32'h00001234, 0, 32'h0, 1'b0, 1, 0, 1, 32'h80000004, 32'h12340000, 4'b1100});
    vq.push_back('{0, 1'b0, 32'h80000004, 2'd2, 1'b0, 32'h0, 0, 32'h12340000, 1'b0, 1, 1, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{0, 1'b1, 32'h80000008, 2'd3, 1'b0, 32'hFFFFFFFF, 0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{0, 1'b1, 32'h80000003, 2'd1, 1'b0, 32'hFFFFFFFF, 0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{2, 1'b1, 32'h80000007, 2'd2, 1'b0, 32'hCAFEF00D, 0, 32'h0, 1'b0, 2, 0, 1, 32'h80000004, 32'hCAFEF00D, 4'b1111});
    vq.push_back('{2, 1'b0, 32'h80000005, 2'd0, 1'b0, 32'h0, 0, 32'hFFFFFFF0, 1'b0, 2, 1, 0, 32'h0, 32'h0, 4'h0});
    vq.push_back('{1, 1'b0, 32'h80000004, 2'd2, 1'b0, 32'h0, 3, 32'hCAFEF00D, 1'b0, 4, 1, 0, 32'h0, 32'h0, 4'h0});
    sel = 0; t_v = 1'b0; t_rr = 1'b0; t_wen = 1'b0; t_uns = 1'b0; t_addr = 32'h0; t_wdata = 32'h0; t_size = 2'd0;
    rst = 1'b1; init_mem = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, rv[0]}, 32'd0);
    chk("rst_ready", {31'd0, rdy[0]}, 32'd0);
    chk("rst_busy", {31'd0, bsy[0]}, 32'd0);
    chk("rst_rdata", rdat[0], 32'd0);
    chk("rst_err", {31'd0, rerr[0]}, 32'd0);
    rst = 1'b0; init_mem = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, rdy[0]}, 32'd1);
    foreach (vq[i]) begin
      nr0 = nr; nw0 = nw;
      xact(vq[i].s, vq[i].wen, vq[i].addr, vq[i].size, vq[i].uns, vq[i].wdata, vq[i].hold, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, vq[i].rd);
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vq[i].err});
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vq[i].lat));
      chk($sformatf("v%0d_nread", i), 32'(nr - nr0), 32'(vq[i].nr));
      chk($sformatf("v%0d_nwrite", i), 32'(nw - nw0), 32'(vq[i].nw));
      if (vq[i].nw != 0) begin
        chk($sformatf("v%0d_waddr", i), last_wa, vq[i].wa);
        chk($sformatf("v%0d_wdata", i), last_wd, vq[i].wd);
        chk($sformatf("v%0d_wmask", i), {28'd0, last_wm}, {28'd0, vq[i].wm});
      end
    end
    // LATENCY=4 with a stalled consumer and a request held valid throughout
    nr0 = nr;
    sel = 1; t_wen = 1'b0; t_addr = 32'h80000000; t_size = 2'd2; t_uns = 1'b0; t_v = 1'b1;
    @(negedge clk);
    for (int c = 1; c < 4; c++) begin
      chk($sformatf("l4_wait%0d_valid", c), {31'd0, rv[1]}, 32'd0);
      chk($sformatf("l4_wait%0d_ready", c), {31'd0, rdy[1]}, 32'd0);
      chk($sformatf("l4_wait%0d_busy", c), {31'd0, bsy[1]}, 32'd1);
      @(negedge clk);
    end
    chk("l4_valid", {31'd0, rv[1]}, 32'd1);
    chk("l4_rdata", rdat[1], 32'hDEADAAEF);
    repeat (3) begin
      @(negedge clk);
      chk("l4_stall_valid", {31'd0, rv[1]}, 32'd1);
      chk("l4_stall_ready", {31'd0, rdy[1]}, 32'd0);
      chk("l4_stall_rdata", rdat[1], 32'hDEADAAEF);
    end
    t_rr = 1'b1;
    chk("l4_take_ready", {31'd0, rdy[1]}, 32'd0);
    @(negedge clk);
    t_rr = 1'b0;
    chk("l4_after_valid", {31'd0, rv[1]}, 32'd0);
    chk("l4_after_ready", {31'd0, rdy[1]}, 32'd1);
    t_v = 1'b0;
    chk("l4_single_read", 32'(nr - nr0), 32'd1);
    @(negedge clk);
    // reset while the LATENCY=4 bridge is counting down
    t_v = 1'b1;
    @(negedge clk);
    t_v = 1'b0;
    chk("mid_busy", {31'd0, bsy[1]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, rv[1]}, 32'd0);
    chk("mid_rst_busy", {31'd0, bsy[1]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", {31'd0, rdy[1]}, 32'd1);
    xact(1, 1'b0, 32'h80000000, 2'd2, 1'b0, 32'h0, 0, rd, er, lat);
    chk("post_rst_rdata", rd, 32'hDEADAAEF);
    chk("post_rst_lat", 32'(lat), 32'd4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
